bg_output_xbar_pipe: RTL and testbench
======================================

Name: bg_output_xbar_pipe

Overview:
- Parametrised successor of the bank-group output stage.
- Takes NB bank read lanes of DW bits each and produces NB output lanes.
- NTT mode: lane-for-lane pass-through. MSM mode: one lane per bank group is gathered into output lanes 0..NG-1, selected by a replicated one-hot chip-enable vector.
- Adds valid/ready flow control with a 2-entry skid buffer and flags illegal selects, so downstream MSM/NTT cores can stall without losing bank reads.

Parameters:
- DW, 256, data width of one lane
- NB, 32, number of bank lanes (power of 2)
- NG, 4, number of bank groups in MSM mode (power of 2, NG ≤ NB)
- L, NB/NG, lanes per group (derived localparam, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flag_msm  in  1  0 = NTT pass-through, 1 = MSM gather; sampled with each accepted beat
- ce_in  in  NB  chip-enable vector from the bank-group input logic; sampled with each accepted beat
- din  in  NB*DW  flattened lanes; lane i = din[i*DW +: DW]
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- dout  out  NB*DW  flattened output lanes
- out_err  out  1  current output beat came from an illegal MSM select
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high on rst.
- Reset values: out_valid=0, dout=0, out_err=0, skid empty, in_ready=1 on the first cycle after rst deasserts. Asserting rst mid-operation discards all held beats immediately.
- Transfer rules:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - dout and out_err hold stable while out_valid=1 and out_ready=0.
- NTT beat (flag_msm=0): output lane i = din lane i for all i; out_err=0. ce_in is ignored.
- MSM beat (flag_msm=1):
  - Legal iff ce_in equals NG copies of the same L-bit one-hot pattern p. k = index of the set bit in p.
  - Output lane g (g < NG) = din lane (bitrev_log2NG(g)*L + k). For NG=4, L=8, k=0 this gives lanes {0,16,8,24}.
  - Output lanes NG..NB-1 = 0.
- Illegal MSM select (zero, multi-hot, or copies that differ): all output lanes = 0, out_err=1. The beat is still delivered and counted; it is never dropped.
- Datapath: the mux result is computed combinationally from din and registered. Latency is exactly 1 cycle from input transfer to out_valid when the pipe is not stalled.
- State machine, occupancy of main register + skid register:
  - EMPTY: in_ready=1. Input transfer -> ONE.
  - ONE: in_ready=1.
    - input and output transfer together -> ONE (main register reloads).
    - input only -> TWO (new beat goes to skid).
    - output only -> EMPTY.
  - TWO: in_ready=0.
    - output transfer -> ONE (skid moves to main).
    - An input transfer cannot occur in this state.
- in_ready is a registered function of state only (no combinational path from out_ready).
- Throughput: one beat per cycle sustained while out_ready=1.
- Mode change between beats needs no drain. Mode travels with each beat.

Optional Feature:
- Macro: BG_OUT_ERR_CNT_EN.
- Defined:
  - Extra output port err_cnt [15:0], reset to 0.
  - Increments by 1 on each output transfer with out_err=1; saturates at 16'hFFFF.
  - Extra input port err_clr: synchronous clear, which takes priority over increment in the same cycle.
- Undefined: neither port exists; out_err behaviour is unchanged.

Decomposition:
- Package bg_out_pkg:
  - mode enum (MODE_NTT=0, MODE_MSM=1)
  - state enum (ST_EMPTY, ST_ONE, ST_TWO)
  - bitrev function
  - one-hot legality/index function, parameterised through the function arguments
- Sub-module bg_msm_gather: purely combinational. Inputs ce_in, din, flag_msm; outputs mux lanes and err. It is instanced once before the skid pipeline so the gather logic can be checked on its own.

Test Plan:
- NTT pass-through: flag_msm=0, lane i = i+1, out_ready=1 -> one cycle later out_valid=1, lane i = i+1, out_err=0.
- MSM legal: ce_in=32'h0404_0404, lane i = 100+i -> lanes 0..3 = {102,118,110,126}, lanes 4..31 = 0, out_err=0.
- MSM illegal: ce_in=32'h0404_0408 -> all lanes 0, out_err=1. With BG_OUT_ERR_CNT_EN, err_cnt 0→1.
- Backpressure: 3 back-to-back beats A,B,C with out_ready=0 -> A accepted, B accepted, in_ready=0 in the cycle C is presented. Release out_ready -> outputs A, B, C in order, none lost or duplicated.
- Streaming: alternate flag_msm every beat over 64 beats with out_ready=1 -> one output per cycle, each beat matches the model for its own mode.
- Reset mid-stream: assert rst while in ST_TWO -> out_valid=0 and dout=0 immediately. After rst release, in_ready=1 and no old beat appears.

Source files
------------

// File: rtl/bg_out_pkg.sv
// Shared types and helpers for the bank-group output crossbar pipe.
// Holds mode/state enums, lane bit-reversal and chip-enable legality check.
package bg_out_pkg;

  // Widest chip-enable vector the legality helper handles.
  localparam int CE_MAX = 1024;

  typedef enum logic {
    MODE_NTT = 1'b0,
    MODE_MSM = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Reverse the low 'bits' bits of v.
  function automatic int bitrev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) begin
      if (((v >> i) & 1) != 0) begin
        r = r | (1 << (bits - 1 - i));
      end
    end
    return r;
  endfunction

  // Legal when ce holds ng identical copies of one L-bit one-hot
  // pattern (L = nb/ng); k is the index of the set bit.
  function automatic logic ce_legal(
    input  logic [CE_MAX-1:0] ce,
    input  int                nb,
    input  int                ng,
    output int                k
  );
    int   l;
    int   cnt;
    logic ok;
    l   = nb / ng;
    cnt = 0;
    k   = 0;
    ok  = 1'b1;
    for (int i = 0; i < l; i++) begin
      if (ce[i]) begin
        cnt = cnt + 1;
        k   = i;
      end
    end
    if (cnt != 1) begin
      ok = 1'b0;
    end
    for (int j = l; j < nb; j++) begin
      if (ce[j] != ce[j % l]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bg_msm_gather.sv
// Combinational lane mux: NTT pass-through or MSM per-group gather.
// Ports: ce_in, din, flag_msm in; lanes (NB*DW), err out.
module bg_msm_gather
  import bg_out_pkg::*;
#(
  parameter int DW = 256,
  parameter int NB = 32,
  parameter int NG = 4
) (
  input  logic [NB-1:0]    ce_in,
  input  logic [NB*DW-1:0] din,
  input  logic             flag_msm,
  output logic [NB*DW-1:0] lanes,
  output logic             err
);

  localparam int L  = NB / NG;
  localparam int LG = $clog2(NG);

  logic [CE_MAX-1:0] ce_ext;
  logic              legal;
  int                k;

  always_comb begin
    ce_ext          = '0;
    ce_ext[NB-1:0]  = ce_in;
    lanes           = '0;
    err             = 1'b0;
    legal           = 1'b0;
    k               = 0;
    unique case (mode_e'(flag_msm))
      MODE_NTT: begin
        lanes = din;
      end
      MODE_MSM: begin
        legal = ce_legal(ce_ext, NB, NG, k);
        if (legal) begin
          // Group g lands on lane g; source group is bit-reversed.
          for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < L; i++) begin
              if (i == k) begin
                lanes[g*DW +: DW] =
                  din[(bitrev(g, LG)*L + i)*DW +: DW];
              end
            end
          end
        end else begin
          err = 1'b1;
        end
      end
      default: begin
        lanes = '0;
      end
    endcase
  end

endmodule

// File: rtl/bg_output_xbar_pipe.sv
// Bank-group output crossbar with valid/ready and 2-entry skid pipe.
// Ports: clk, rst, flag_msm, ce_in, din, in_valid/in_ready,
// dout, out_err, out_valid/out_ready.
// Optional BG_OUT_ERR_CNT_EN adds err_clr in, err_cnt[15:0] out.
module bg_output_xbar_pipe
  import bg_out_pkg::*;
#(
  parameter int DW = 256,
  parameter int NB = 32,
  parameter int NG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_msm,
  input  logic [NB-1:0]    ce_in,
  input  logic [NB*DW-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NB*DW-1:0] dout,
  output logic             out_err,
  input  logic             out_ready,
`ifdef BG_OUT_ERR_CNT_EN
  input  logic             err_clr,
  output logic [15:0]      err_cnt,
`endif
  output logic             out_valid
);

  logic [NB*DW-1:0] mux_d;
  logic             mux_e;
  logic [NB*DW-1:0] main_d;
  logic             main_e;
  logic [NB*DW-1:0] skid_d;
  logic             skid_e;
  state_e           st_q;
  state_e           st_n;
  logic             in_xfer;
  logic             out_xfer;
  logic             ld_main_mux;
  logic             ld_main_skid;
  logic             ld_skid;

  bg_msm_gather #(
    .DW(DW),
    .NB(NB),
    .NG(NG)
  ) u_gather (
    .ce_in   (ce_in),
    .din     (din),
    .flag_msm(flag_msm),
    .lanes   (mux_d),
    .err     (mux_e)
  );

  assign in_xfer   = in_valid & in_ready;
  assign out_valid = (st_q != ST_EMPTY);
  assign out_xfer  = out_valid & out_ready;
  assign dout      = main_d;
  assign out_err   = main_e;

  always_comb begin
    st_n         = st_q;
    ld_main_mux  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (st_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          st_n        = ST_ONE;
          ld_main_mux = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          ld_main_mux = 1'b1;
        end else if (in_xfer) begin
          st_n    = ST_TWO;
          ld_skid = 1'b1;
        end else if (out_xfer) begin
          st_n = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          st_n         = ST_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: begin
        st_n = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      st_q     <= st_n;
      // Registered from next state: no path from out_ready.
      in_ready <= (st_n != ST_TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_d <= '0;
      main_e <= 1'b0;
      skid_d <= '0;
      skid_e <= 1'b0;
    end else begin
      if (ld_main_mux) begin
        main_d <= mux_d;
        main_e <= mux_e;
      end else if (ld_main_skid) begin
        main_d <= skid_d;
        main_e <= skid_e;
      end
      if (ld_skid) begin
        skid_d <= mux_d;
        skid_e <= mux_e;
      end
    end
  end

`ifdef BG_OUT_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 16'h0000;
    end else if (err_clr) begin
      err_cnt <= 16'h0000;
    end else if (out_xfer && main_e && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_bg_output_xbar_pipe.sv
// Scoreboard bench for bg_output_xbar_pipe (NB=32, NG=4, DW=16).
// Driver pushes expected beats; a negedge monitor pops and compares.
module tb_bg_output_xbar_pipe;

  localparam int DW = 16;
  localparam int NB = 32;
  localparam int NG = 4;
  localparam int W  = NB * DW;

  typedef struct packed {
    logic         e;
    logic [W-1:0] d;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          flag_msm;
  logic [NB-1:0] ce_in;
  logic [W-1:0]  din;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  dout;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;
`ifdef BG_OUT_ERR_CNT_EN
  logic          err_clr;
  logic [15:0]   err_cnt;
`endif

  beat_t sbq[$];
  int    passed;
  int    total;
  int    outs;

  bg_output_xbar_pipe #(
    .DW(DW),
    .NB(NB),
    .NG(NG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flag_msm (flag_msm),
    .ce_in    (ce_in),
    .din      (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .out_err  (out_err),
    .out_ready(out_ready),
`ifdef BG_OUT_ERR_CNT_EN
    .err_clr  (err_clr),
    .err_cnt  (err_cnt),
`endif
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total = total + 1;
    if (act === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model written from the lane-mapping rules.
  function automatic beat_t model(input logic f, input logic [NB-1:0] ce,
                                  input logic [W-1:0] d);
    beat_t      r;
    logic [7:0] p;
    int         k;
    int         src;
    r.d = '0;
    r.e = 1'b0;
    if (!f) begin
      r.d = d;
    end else begin
      p = ce[7:0];
      if ($countones(p) == 1 && ce[15:8] == p && ce[23:16] == p &&
          ce[31:24] == p) begin
        k = 0;
        for (int i = 0; i < 8; i++) if (p[i]) k = i;
        for (int g = 0; g < 4; g++) begin
          src = (((g & 1) * 2) + (g >> 1)) * 8 + k;
          r.d[g*DW +: DW] = d[src*DW +: DW];
        end
      end else begin
        r.e = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic send(input logic f, input logic [NB-1:0] ce,
                      input logic [W-1:0] d, input beat_t exp,
                      output int waited);
    flag_msm = f;
    ce_in    = ce;
    din      = d;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited = waited + 1;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      total = total + 1;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else begin
      sbq.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sbq.size() > 0 && c < 100) begin
      @(negedge clk);
      c = c + 1;
    end
    total = total + 1;
    if (sbq.size() == 0) passed = passed + 1;
    else $display("FAIL drain: got %0d pending want 0", sbq.size());
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each output transfer, check hold under stall.
  initial begin : monitor
    beat_t        ex;
    logic [W-1:0] hold_d;
    logic         hold_e;
    logic         hold_v;
    hold_v = 1'b0;
    hold_d = '0;
    hold_e = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && out_valid) begin
          chk("hold_dout", dout, hold_d);
          chk("hold_err", W'(out_err), W'(hold_e));
        end
        hold_v = out_valid && !out_ready;
        hold_d = dout;
        hold_e = out_err;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            total = total + 1;
            $display("FAIL unexpected_out: got beat %0h want none", dout);
          end else begin
            ex = sbq.pop_front();
            chk("dout", dout, ex.d);
            chk("out_err", W'(out_err), W'(ex.e));
            outs = outs + 1;
          end
        end
      end
    end
  end

  initial begin : stim
    logic [W-1:0]  d;
    logic [NB-1:0] ce;
    logic [7:0]    p;
    beat_t         e;
    beat_t         ea;
    beat_t         eb;
    beat_t         ec;
    int            w;
    int            o0;
    logic          f;

    passed    = 0;
    total     = 0;
    outs      = 0;
    rst       = 1'b1;
    flag_msm  = 1'b0;
    ce_in     = '0;
    din       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef BG_OUT_ERR_CNT_EN
    err_clr   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_dout", dout, '0);
    chk("rst_out_err", W'(out_err), W'(1'b0));
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
`ifdef BG_OUT_ERR_CNT_EN
    chk("rst_err_cnt", W'(err_cnt), W'(16'd0));
`endif
    @(posedge clk);
    #1;

    // NTT pass-through, lane i = i+1.
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = DW'(i + 1);
    e.d = d;
    e.e = 1'b0;
    send(1'b0, 32'hFFFF_0000, d, e, w);
    @(negedge clk);
    chk("ntt_lat_valid", W'(out_valid), W'(1'b1));
    drain();

    // MSM legal, k=2: lanes {102,118,110,126}.
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = DW'(100 + i);
    e.d = '0;
    e.e = 1'b0;
    e.d[0*DW +: DW] = 16'd102;
    e.d[1*DW +: DW] = 16'd118;
    e.d[2*DW +: DW] = 16'd110;
    e.d[3*DW +: DW] = 16'd126;
    send(1'b1, 32'h0404_0404, d, e, w);
    drain();

    // MSM illegal: copies differ.
    e.d = '0;
    e.e = 1'b1;
    send(1'b1, 32'h0404_0408, d, e, w);
    drain();
`ifdef BG_OUT_ERR_CNT_EN
    chk("err_cnt_inc", W'(err_cnt), W'(16'd1));
`endif

    // Illegal: zero and multi-hot.
    send(1'b1, 32'h0000_0000, d, e, w);
    send(1'b1, 32'h0303_0303, d, e, w);
    drain();

    // Backpressure: A, B held, C blocked until release.
    out_ready = 1'b0;
    o0 = outs;
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = DW'(16'h0A00 + i);
    ea.d = d;
    ea.e = 1'b0;
    send(1'b0, '0, d, ea, w);
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = DW'(16'h0B00 + i);
    eb = '0;
    eb.d[0*DW +: DW] = 16'h0B00;
    eb.d[1*DW +: DW] = 16'h0B10;
    eb.d[2*DW +: DW] = 16'h0B08;
    eb.d[3*DW +: DW] = 16'h0B18;
    send(1'b1, 32'h0101_0101, d, eb, w);
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = DW'(16'h0C00 + i);
    ec.d = d;
    ec.e = 1'b0;
    flag_msm = 1'b0;
    din      = d;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", W'(in_ready), W'(1'b0));
    fork
      send(1'b0, '0, d, ec, w);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", W'(outs - o0), W'(3));

    // Streaming with alternating mode.
    o0 = outs;
    for (int n = 0; n < 64; n++) begin
      f = n[0];
      for (int i = 0; i < NB; i++) d[i*DW +: DW] = DW'(n * 40 + i * 3 + 7);
      p  = 8'(1 << (n % 8));
      ce = {p, p, p, p};
      if (n % 7 == 3) ce = ce ^ 32'h0100_0000;
      send(f, ce, d, model(f, ce, d), w);
      chk("stream_no_wait", W'(w), W'(0));
    end
    drain();
    chk("stream_count", W'(outs - o0), W'(64));

    // Reset while two beats are held.
    out_ready = 1'b0;
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = DW'(16'h0D00 + i);
    send(1'b0, '0, d, model(1'b0, '0, d), w);
    send(1'b1, 32'h8080_8080, d, model(1'b1, 32'h8080_8080, d), w);
    @(negedge clk);
    chk("two_in_ready", W'(in_ready), W'(1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", W'(out_valid), W'(1'b0));
    chk("mrst_dout", dout, '0);
    chk("mrst_out_err", W'(out_err), W'(1'b0));
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", W'(in_ready), W'(1'b1));
    chk("post_rst_valid", W'(out_valid), W'(1'b0));
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_no_beat", W'(out_valid), W'(1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
